// File: rtl/bnn_pkg.sv
// Shared definitions for the BNN classifier blocks.
//   fc_state_e   : fully-connected layer controller states
//   FC_N_FMAP    : number of conv feature maps feeding the FC layer
//   FC_FMAP_WORDS: words per feature map
//   FC_N_IN      : flattened feature words per inference
//   FC_N_CLASS   : default number of output classes
//   FC_DW        : default feature word width
//   fc_acc_width : conservative accumulator width bound for n_in words of dw bits
package bnn_pkg;

    typedef enum logic [1:0] {
        FcIdle,
        FcAccum,
        FcArgmax,
        FcDone
    } fc_state_e;

    localparam int unsigned FC_N_FMAP     = 6;
    localparam int unsigned FC_FMAP_WORDS = 144;
    localparam int unsigned FC_N_IN       = FC_N_FMAP * FC_FMAP_WORDS;
    localparam int unsigned FC_N_CLASS    = 10;
    localparam int unsigned FC_DW         = 32;

    // Upper bound on the signed accumulator width; it keeps one spare bit over the
    // tight bound when n_in is not a power of two.
    function automatic int unsigned fc_acc_width(int unsigned n_in, int unsigned dw);
        return $clog2(n_in) + dw + 1;
    endfunction

endpackage

// File: rtl/fc_argmax_scan.sv
// Sequential arg-max search over a flattened bank of signed accumulators.
//   clk, rstn   : clock, asynchronous active-low reset
//   start_i     : pulse one cycle before the first class is examined
//   acc_i       : N_CLASS signed AW-bit scores, class k in slice k
//   idx_o       : class examined this cycle
//   done_o      : high in the cycle the last class is examined
//   best_idx_o  : winning index including the class examined this cycle
// One class is examined per cycle, so a scan takes N_CLASS cycles after start_i.
// Only strictly greater scores replace the incumbent, so ties go to the lowest index.
module fc_argmax_scan
    import bnn_pkg::*;
#(
    parameter  int unsigned N_CLASS = FC_N_CLASS,
    parameter  int unsigned AW      = 42,
    localparam int unsigned IW      = (N_CLASS > 1) ? $clog2(N_CLASS) : 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start_i,
    input  logic [N_CLASS*AW-1:0] acc_i,
    output logic [IW-1:0]        idx_o,
    output logic                 done_o,
    output logic [IW-1:0]        best_idx_o
);

    logic [IW-1:0]        idx_q;
    logic                 run_q;
    logic signed [AW-1:0] best_val_q;
    logic [IW-1:0]        best_idx_q;
    logic signed [AW-1:0] cur_val;
    logic                 take;

    assign cur_val = $signed(acc_i[idx_q*AW +: AW]);
    // Class 0 seeds the incumbent unconditionally.
    assign take    = (idx_q == '0) || (cur_val > best_val_q);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idx_q      <= '0;
            run_q      <= 1'b0;
            best_val_q <= '0;
            best_idx_q <= '0;
        end else if (start_i) begin
            idx_q <= '0;
            run_q <= 1'b1;
        end else if (run_q) begin
            if (take) begin
                best_val_q <= cur_val;
                best_idx_q <= idx_q;
            end
            if (idx_q == IW'(N_CLASS - 1)) begin
                run_q <= 1'b0;
            end else begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

    assign idx_o      = idx_q;
    assign done_o     = run_q && (idx_q == IW'(N_CLASS - 1));
    assign best_idx_o = (run_q && take) ? idx_q : best_idx_q;

endmodule

// File: rtl/fc_binary_classifier.sv
// Fully-connected binarized output layer: accumulates +/-din per class from a
// stream of N_IN signed words, then reports the arg-max class as a one-hot vector.
//   clk, rstn    : clock, asynchronous active-low reset (aborts any inference)
//   start_i      : begin an inference; honoured only when idle
//   din_valid_i  : feature word valid
//   din_i        : signed feature word
//   wgt_i        : weight bits for din_i, bit k for class k (1 = +1, 0 = -1)
//   bias_i       : per-class signed bias, only when FC_BIAS_EN is defined
//   din_ready_o  : word accepted this cycle when din_valid_i is also high
//   classes_o    : one-hot winner, held until the next accepted start
//   done_o       : one-cycle pulse when classes_o becomes valid
//   busy_o       : high whenever not idle
// Build option: FC_BIAS_EN loads accumulators from bias_i on start instead of 0.
// Accumulators wrap modulo 2^AW if AW is reduced below the no-overflow width.
module fc_binary_classifier
    import bnn_pkg::*;
#(
    parameter  int unsigned N_IN    = FC_N_IN,
    parameter  int unsigned N_CLASS = FC_N_CLASS,
    parameter  int unsigned DW      = FC_DW,
    parameter  int unsigned AW      = 42,
    localparam int unsigned IW      = (N_CLASS > 1) ? $clog2(N_CLASS) : 1,
    localparam int unsigned CW      = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start_i,
    input  logic                  din_valid_i,
    input  logic [DW-1:0]         din_i,
    input  logic [N_CLASS-1:0]    wgt_i,
`ifdef FC_BIAS_EN
    input  logic [N_CLASS*DW-1:0] bias_i,
`endif
    output logic                  din_ready_o,
    output logic [N_CLASS-1:0]    classes_o,
    output logic                  done_o,
    output logic                  busy_o
);

    fc_state_e            state_q;
    logic [CW-1:0]        cnt_q;
    logic signed [AW-1:0] acc_q    [N_CLASS];
    logic signed [AW-1:0] acc_init [N_CLASS];
    logic [N_CLASS*AW-1:0] acc_flat;
    logic [N_CLASS-1:0]   classes_q;
    logic                 done_q;
    logic                 din_ready_q;
    logic                 busy_q;

    logic                 xfer;
    logic                 last_word;
    logic signed [AW-1:0] din_ext;
    logic                 scan_start;
    logic                 scan_done;
    logic [IW-1:0]        scan_idx;
    logic [IW-1:0]        scan_best_idx;

    assign xfer       = din_valid_i && din_ready_q;
    assign last_word  = (cnt_q == CW'(N_IN - 1));
    assign din_ext    = {{(AW - DW){din_i[DW-1]}}, din_i};
    // The scan seeds from acc[0] one cycle later, after the last word has landed.
    assign scan_start = (state_q == FcAccum) && xfer && last_word;

    always_comb begin
        for (int k = 0; k < N_CLASS; k++) begin
            acc_init[k] = '0;
`ifdef FC_BIAS_EN
            acc_init[k] = {{(AW - DW){bias_i[k*DW + DW - 1]}}, bias_i[k*DW +: DW]};
`endif
        end
    end

    always_comb begin
        acc_flat = '0;
        for (int k = 0; k < N_CLASS; k++) begin
            acc_flat[k*AW +: AW] = acc_q[k];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= FcIdle;
            cnt_q       <= '0;
            classes_q   <= '0;
            done_q      <= 1'b0;
            din_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            for (int k = 0; k < N_CLASS; k++) begin
                acc_q[k] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                FcIdle: begin
                    if (start_i) begin
                        for (int k = 0; k < N_CLASS; k++) begin
                            acc_q[k] <= acc_init[k];
                        end
                        cnt_q       <= '0;
                        classes_q   <= '0;
                        din_ready_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= FcAccum;
                    end
                end
                FcAccum: begin
                    if (xfer) begin
                        for (int k = 0; k < N_CLASS; k++) begin
                            acc_q[k] <= wgt_i[k] ? acc_q[k] + din_ext : acc_q[k] - din_ext;
                        end
                        cnt_q <= cnt_q + 1'b1;
                        if (last_word) begin
                            din_ready_q <= 1'b0;
                            state_q     <= FcArgmax;
                        end
                    end
                end
                FcArgmax: begin
                    if (scan_done && (scan_idx == IW'(N_CLASS - 1))) begin
                        classes_q <= N_CLASS'(1) << scan_best_idx;
                        done_q    <= 1'b1;
                        state_q   <= FcDone;
                    end
                end
                FcDone: begin
                    busy_q  <= 1'b0;
                    state_q <= FcIdle;
                end
                default: state_q <= FcIdle;
            endcase
        end
    end

    fc_argmax_scan #(
        .N_CLASS (N_CLASS),
        .AW      (AW)
    ) u_scan (
        .clk        (clk),
        .rstn       (rstn),
        .start_i    (scan_start),
        .acc_i      (acc_flat),
        .idx_o      (scan_idx),
        .done_o     (scan_done),
        .best_idx_o (scan_best_idx)
    );

    assign din_ready_o = din_ready_q;
    assign classes_o   = classes_q;
    assign done_o      = done_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_fc_binary_classifier.sv
// Scoreboard bench for fc_binary_classifier: each run pushes the class predicted by a
// plain-arithmetic model of the weighted sums; a monitor pops on every done pulse and
// checks the class, the latency from the last transfer, the transfer count and that
// din_ready stays low outside accumulation.
module tb_fc_binary_classifier;

    localparam int unsigned NI  = 864;
    localparam int unsigned NC  = 10;
    localparam int unsigned DWB = 32;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            start_i = 1'b0;
    logic            din_valid_i = 1'b0;
    logic [DWB-1:0]  din_i = '0;
    logic [NC-1:0]   wgt_i = '0;
    logic            din_ready_o;
    logic [NC-1:0]   classes_o;
    logic            done_o;
    logic            busy_o;
`ifdef FC_BIAS_EN
    logic [NC*DWB-1:0] bias_i = '0;
`endif

    fc_binary_classifier dut (
        .clk         (clk),
        .rstn        (rstn),
        .start_i     (start_i),
        .din_valid_i (din_valid_i),
        .din_i       (din_i),
        .wgt_i       (wgt_i),
`ifdef FC_BIAS_EN
        .bias_i      (bias_i),
`endif
        .din_ready_o (din_ready_o),
        .classes_o   (classes_o),
        .done_o      (done_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [NC-1:0]  sb_q[$];
    logic [DWB-1:0] din_a [NI];
    logic [NC-1:0]  wgt_a [NI];

    int lat      = 1000;
    int xfer_cnt = 0;
    bit ready_bad = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Sum of +/-din per class, then the lowest-index maximum.
    function automatic logic [NC-1:0] ref_class();
        longint s [NC];
        int     best;
        logic [NC-1:0] one;
        for (int k = 0; k < NC; k++) begin
            s[k] = 0;
`ifdef FC_BIAS_EN
            s[k] = longint'($signed(bias_i[k*DWB +: DWB]));
`endif
        end
        for (int i = 0; i < NI; i++) begin
            for (int k = 0; k < NC; k++) begin
                if (wgt_a[i][k]) s[k] += longint'($signed(din_a[i]));
                else             s[k] -= longint'($signed(din_a[i]));
            end
        end
        best = 0;
        for (int k = 1; k < NC; k++) begin
            if (s[k] > s[best]) best = k;
        end
        one = '0;
        one[best] = 1'b1;
        return one;
    endfunction

    task automatic fill(input int mode);
        for (int i = 0; i < NI; i++) begin
            case (mode)
                0: begin din_a[i] = 32'd1;          wgt_a[i] = 10'b0000001000; end
                1: begin din_a[i] = 32'd5;          wgt_a[i] = 10'b1111111111; end
                2: begin din_a[i] = -32'sd7;        wgt_a[i] = 10'b1011111111; end
                4: begin din_a[i] = 32'h8000_0000;  wgt_a[i] = 10'b1111011111; end
                5: begin din_a[i] = 32'd0;          wgt_a[i] = 10'(($urandom)); end
                default: begin din_a[i] = $urandom; wgt_a[i] = 10'($urandom); end
            endcase
        end
    endtask

    // Monitor: samples just after the falling edge, when inputs and outputs are settled.
    always @(negedge clk) begin
        logic [NC-1:0] exp_c;
        #1;
        if (!rstn) begin
            xfer_cnt  = 0;
            lat       = 1000;
            ready_bad = 1'b0;
        end else begin
            if (din_ready_o && (!busy_o || done_o || xfer_cnt == NI)) ready_bad = 1'b1;
            if (din_valid_i && din_ready_o) begin
                lat = 0;
                xfer_cnt++;
            end else if (lat < 1000) begin
                lat++;
            end
            if (done_o) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 64'(done_o), 64'd0);
                end else begin
                    exp_c = sb_q.pop_front();
                    check("classes", 64'(classes_o), 64'(exp_c));
                    check("latency", 64'(lat), 64'd11);
                    check("transfers", 64'(xfer_cnt), 64'(NI));
                    check("ready_outside_accum", 64'(ready_bad), 64'd0);
                end
                xfer_cnt  = 0;
                ready_bad = 1'b0;
            end
        end
    end

    // The word offered alongside start must be dropped.
    task automatic do_start();
        @(negedge clk);
        start_i     = 1'b1;
        din_valid_i = 1'b1;
        din_i       = 32'h7fff_ffff;
        wgt_i       = '1;
        @(negedge clk);
        start_i     = 1'b0;
        din_valid_i = 1'b0;
    endtask

    task automatic feed(input int gap_pct, input int mid_start_at, input int abort_at);
        int i;
        int guard;
        bit mid_done;
        i = 0;
        guard = 0;
        mid_done = 1'b0;
        while (i < NI) begin
            if (i == abort_at) break;
            @(negedge clk);
            start_i = 1'b0;
            if (i == mid_start_at && !mid_done) begin
                start_i  = 1'b1;
                mid_done = 1'b1;
            end
            if (int'($urandom_range(99)) < gap_pct) begin
                din_valid_i = 1'b0;
            end else begin
                din_valid_i = 1'b1;
                din_i       = din_a[i];
                wgt_i       = wgt_a[i];
            end
            if (din_valid_i && din_ready_o) i++;
            guard++;
            if (guard > 20000) begin
                check("feed_timeout", 64'(i), 64'(NI));
                break;
            end
        end
        @(negedge clk);
        din_valid_i = 1'b0;
        start_i     = 1'b0;
    endtask

    task automatic run(input string name, input int gap_pct, input int mid_at);
        logic [NC-1:0] e;
        int guard;
        e = ref_class();
        sb_q.push_back(e);
        do_start();
        feed(gap_pct, mid_at, -1);
        guard = 0;
        while (sb_q.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (sb_q.size() != 0) begin
            $display("FAIL done_timeout in %s: pending %0d expected 0", name, sb_q.size());
            total++;
            bad++;
            sb_q.delete();
            rstn = 1'b0;
            @(negedge clk);
            rstn = 1'b1;
        end
        repeat (3) @(negedge clk);
        check({name, "_hold"}, 64'(classes_o), 64'(e));
        check({name, "_idle"}, 64'(busy_o), 64'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_ready",   64'(din_ready_o), 64'd0);
        check("rst_busy",    64'(busy_o),      64'd0);
        check("rst_done",    64'(done_o),      64'd0);
        check("rst_classes", 64'(classes_o),   64'd0);
        rstn = 1'b1;

        fill(0); run("class_select", 0, -1);
        fill(1); run("tie_break", 0, -1);
        fill(2); run("signed_data", 0, -1);
        fill(4); run("full_scale", 0, -1);
        fill(3); run("random_nogap", 0, -1);
        run("random_gaps", 70, -1);
        fill(3); run("mid_start", 20, 500);

        // Abort after 400 words, then a fresh run must still be correct.
        fill(3);
        do_start();
        feed(0, -1, 400);
        check("abort_busy_before", 64'(busy_o), 64'd1);
        rstn = 1'b0;
        #1;
        check("abort_ready",   64'(din_ready_o), 64'd0);
        check("abort_busy",    64'(busy_o),      64'd0);
        check("abort_done",    64'(done_o),      64'd0);
        check("abort_classes", 64'(classes_o),   64'd0);
        @(negedge clk);
        rstn = 1'b1;
        run("after_reset", 10, -1);

        // Reset while idle clears a held result.
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check("idle_rst_classes", 64'(classes_o), 64'd0);
        @(negedge clk);
        rstn = 1'b1;

`ifdef FC_BIAS_EN
        fill(5);
        bias_i = '0;
        bias_i[6*DWB +: DWB] = 32'd100;
        run("bias", 0, -1);
        check("bias_class", 64'(classes_o), 64'h40);
`endif

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
